// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/DMA memory arbiter: FSM state codes and requester indices.
package mem_arb_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_ACCESS = 2'b01;
  localparam logic [1:0] ARB_DONE   = 2'b10;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin selector: a tie goes to the port not granted last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       grant
);

  assign valid = |req;
  assign grant = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one variable-latency memory port between CPU (p0) and DMA (p1).
// Optional ACCESS watchdog: define MEM_ARB_TIMEOUT_EN to abort stuck accesses with err=1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  logic [1:0]         state_q, state_d;
  logic               last_q, last_d;
  logic               win_q, win_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [1:0]         ack_q, ack_d;
  logic [1:0][DW-1:0] rdata_q, rdata_d;
  logic               pick_valid, pick_grant;
  logic               pick_dma;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_pick2 u_pick (
    .req        ({p1_req, p0_req}),
    .last_grant (last_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  assign pick_dma = (pick_grant == 1'(PORT_DMA));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d   = '0;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          we_d    = pick_dma ? p1_we    : p0_we;
          addr_d  = pick_dma ? p1_addr  : p0_addr;
          wdata_d = pick_dma ? p1_wdata : p0_wdata;
          req_d   = 1'b1;
          last_d  = pick_grant;
          win_d   = pick_grant;
          state_d = ARB_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_ACCESS: begin
        if (mem_ready) begin
          // Writes complete without disturbing the port's last read value.
          if (!we_q) rdata_d[win_q] = mem_rdata;
          ack_d[win_q] = 1'b1;
          req_d        = 1'b0;
          state_d      = ARB_DONE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          ack_d[win_q] = 1'b1;
          err_d[win_q] = 1'b1;
          req_d        = 1'b0;
          state_d      = ARB_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'(PORT_DMA);
      win_q   <= 1'(PORT_CPU);
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign p0_ack    = ack_q[PORT_CPU];
  assign p1_ack    = ack_q[PORT_DMA];
  assign p0_rdata  = rdata_q[PORT_CPU];
  assign p1_rdata  = rdata_q[PORT_DMA];
`ifdef MEM_ARB_TIMEOUT_EN
  assign p0_err    = err_q[PORT_CPU];
  assign p1_err    = err_q[PORT_DMA];
`else
  assign p0_err    = 1'b0;
  assign p1_err    = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single shared instruction/data memory port of the multicycle RISC-V core. Requester 0 is the CPU memory interface (instruction fetch, load and store). Requester 1 is the DMA/debug loader. The block grants the memory to one requester at a time using round-robin, holds the command stable for the variable-latency memory, and returns a one-cycle acknowledge with read data to the winner.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles before abort (used only with MEM_ARB_TIMEOUT_EN)

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- p0_req / p1_req  in  1  request; held high with fields stable until the matching ack
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  AW  address
- p0_wdata / p1_wdata  in  DW  write data
- p0_ack / p1_ack  out  1  one-cycle completion pulse
- p0_rdata / p1_rdata  out  DW  read data; valid from ack, held until the next ack on the same port
- p0_err / p1_err  out  1  timeout flag; qualified by ack
- mem_req  out  1  memory command valid
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid when mem_ready is high
- mem_ready  in  1  memory completion; sampled only while mem_req is high

## Operation
- The FSM has three states:
  - IDLE:
    - If neither request is high, stay in IDLE.
    - If exactly one request is high, grant it.
    - If both are high, grant the port not granted last.
    - On a grant, register we/addr/wdata into the mem_* outputs, set mem_req=1, record the winner in last_grant, and go to ACCESS.
  - ACCESS:
    - Hold mem_req and the command until mem_ready=1.
    - On mem_ready=1, capture mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged), clear mem_req, and go to DONE.
  - DONE:
    - Pulse the winner's ack for this cycle; no arbitration happens here.
    - Go to IDLE.
- A request still high in IDLE after its ack is a new transaction.
- Requests raised in ACCESS/DONE wait; they are never dropped.
- Reset values:
  - state=IDLE.
  - last_grant=1, so port 0 wins the first tie.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Both acks, errs and rdatas = 0.
- Reset mid-transaction aborts immediately:
  - mem_req drops asynchronously.
  - No ack is issued.
  - The requester must reissue.
- All outputs are registered; there is no combinational path from a request to mem_*.

## Timing
- Request sampled high in IDLE at edge N → mem_req=1 after edge N.
- mem_ready=1 sampled at edge M → ack high during cycle M+1 (DONE).
- Minimum request-to-ack latency is 2 cycles; this occurs when mem_ready is already high in the first ACCESS cycle.
- Back-to-back throughput is one transaction per (memory latency + 2) cycles.
- Under simultaneous contention, ports alternate strictly.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle with mem_ready=0.
  - When it reaches TIMEOUT, drop mem_req, go to DONE, and pulse ack with err=1. rdata is left unchanged.
  - err is 0 on normal completion.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter is built; ACCESS waits indefinitely.
  - p0_err and p1_err are tied to 0.

## Structure
- Package mem_arb_pkg holds:
  - State encoding: ARB_IDLE=2'b00, ARB_ACCESS=2'b01, ARB_DONE=2'b10.
  - Port index constants: PORT_CPU=0, PORT_DMA=1.
- Sub-module rr_pick2 is a combinational 2-way round-robin selector:
  - inputs: req[1:0], last_grant.
  - outputs: valid, grant.
- The FSM, command registers and timeout counter live in mem_arbiter.

## Test plan
- p0 read addr 0x100, mem_ready high immediately with mem_rdata 0x12345678 → mem_req for 1 cycle, p0_ack 2 cycles after request, p0_rdata=0x12345678, p0_err=0.
- p0 and p1 both request reads with req held high for 4 transactions, memory latency 3 → grant order 0,1,0,1; each ack spaced 5 cycles apart.
- p1 write addr 0x40 data 0xCAFEF00D → mem_we=1, mem_addr=0x40, mem_wdata=0xCAFEF00D stable until mem_ready; p1_rdata unchanged.
- Reset asserted mid-ACCESS → mem_req=0 immediately, no ack; after release, the pending p0 request is granted first.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=16, mem_ready held 0 → mem_req drops after 16 ACCESS cycles, p0_ack=1 with p0_err=1.
- mem_ready pulsed while mem_req=0 → ignored; no ack and no rdata change.
